// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] NOP     = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // IDLE: nothing outstanding; BUSY: response will be queued; DROP: response will be discarded
    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_BUSY = 2'd1,
        REQ_DROP = 2'd2
    } req_state_t;

endpackage

// File: rtl/ifetch_fetch_fifo.sv
// Fetch queue: DEPTH-entry circular buffer of {pc, instr}, power-of-two DEPTH >= 2.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         push_ok;
    logic         pop_ok;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding memory request feeding a small fetch queue.
// Optional perf counters (perf_fetched, perf_flushes) when IFETCH_PERF_EN is defined.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushes
`endif
);

    req_state_t   state;
    logic [31:0]  fetch_pc;
    fetch_entry_t push_data;
    fetch_entry_t head;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    // Redirect voids both queue operations in the same cycle.
    assign push      = imem_ack && (state == REQ_BUSY) && !redirect;
    assign pop       = !empty && id_ready && !redirect;
    assign push_data = '{pc: fetch_pc, instr: imem_rdata};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign valid = !empty;
    assign instr = empty ? NOP : head.instr;
    assign pc    = empty ? 32'h0 : head.pc;

    // A new request only leaves IDLE, so nothing is outstanding and !full means room for
    // its response. Leaving BUSY/DROP always passes through IDLE, giving the 2-cycle spacing.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= REQ_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
            fetch_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            case (state)
                REQ_IDLE: begin
                    state     <= REQ_BUSY;
                    imem_req  <= 1'b1;
                    imem_addr <= redirect_pc;
                end
                default: begin
                    if (imem_ack) begin
                        state    <= REQ_IDLE;
                        imem_req <= 1'b0;
                    end else begin
                        state <= REQ_DROP;
                    end
                end
            endcase
        end else begin
            case (state)
                REQ_IDLE: begin
                    if (!full) begin
                        state     <= REQ_BUSY;
                        imem_req  <= 1'b1;
                        imem_addr <= fetch_pc;
                    end
                end
                REQ_BUSY: begin
                    if (imem_ack) begin
                        state    <= REQ_IDLE;
                        imem_req <= 1'b0;
                        fetch_pc <= fetch_pc + PC_STEP;
                    end
                end
                REQ_DROP: begin
                    if (imem_ack) begin
                        state    <= REQ_IDLE;
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= REQ_IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_flushes <= 32'h0;
        end else begin
            if (pop)      perf_fetched <= perf_fetched + 32'd1;
            if (redirect) perf_flushes <= perf_flushes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: 1-cycle-latency memory model, request/pop logging, hand-computed expectations.
`timescale 1ns/1ps
module tb_ifetch;
    import ifetch_pkg::*;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, redirect = 1'b0, id_ready = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        auto_mem = 1'b1, man_ack = 1'b0, mem_ack = 1'b0;
    logic [31:0] man_rdata = 32'h0, mem_rdata = 32'h0;
    logic        imem_ack, imem_req, valid;
    logic [31:0] imem_rdata, imem_addr, instr, pc;

    assign imem_ack   = auto_mem ? mem_ack : man_ack;
    assign imem_rdata = auto_mem ? mem_rdata : man_rdata;

    // second instance only checks RESET_PC wrap-around
    logic        ack2 = 1'b0, req2, valid2;
    logic        redirect2 = 1'b0, id_ready2 = 1'b1;
    logic [31:0] rdata2 = 32'h0, redirect_pc2 = 32'h0, addr2, instr2, pc2;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushes, perf_fetched2, perf_flushes2;
`endif

    ifetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .valid(valid),
        .instr(instr), .pc(pc)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .reset(reset), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .id_ready(id_ready2), .valid(valid2),
        .instr(instr2), .pc(pc2)
`ifdef IFETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_flushes(perf_flushes2)
`endif
    );

    int n_tests = 0, n_fail = 0;
    logic [31:0] reqs[$], reqs2[$];
    logic [63:0] got[$], got2[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // memory for dut: ack one cycle after the request is first seen
    initial begin : mem1
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            mem_ack   = imem_req && req_prev && !mem_ack;
            mem_rdata = imem_addr ^ KEY;
            req_prev  = imem_req;
        end
    end

    // monitor for dut: request rises and accepted pops
    initial begin : mon1
        logic rq;
        rq = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (imem_req && !rq) reqs.push_back(imem_addr);
            if (valid && id_ready && !redirect && !reset) got.push_back({pc, instr});
            rq = imem_req;
        end
    end

    // memory + monitor for dut2 (first few transactions only)
    initial begin : mem2
        logic rp, rq;
        rp = 1'b0;
        rq = 1'b0;
        forever begin
            @(negedge clk);
            ack2   = req2 && rp && !ack2;
            rdata2 = addr2 ^ KEY;
            rp     = req2;
            #2;
            if (req2 && !rq && reqs2.size() < 8) reqs2.push_back(addr2);
            if (valid2 && !reset && got2.size() < 8) got2.push_back({pc2, instr2});
            rq = req2;
        end
    end

    task automatic do_reset(input logic rdy);
        @(negedge clk);
        reset = 1'b1; redirect = 1'b0; auto_mem = 1'b1; man_ack = 1'b0; id_ready = rdy;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        reqs.delete();
        got.delete();
    endtask

    task automatic wait_req(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == a) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int p0, r0, bad;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", imem_req, 1'b0);

        // release; a stray ack in the first cycle must be ignored
        reset = 1'b0; id_ready = 1'b1;
        auto_mem = 1'b0; man_ack = 1'b1; man_rdata = 32'hBAD0_0001;
        reqs.delete(); got.delete();
        @(negedge clk);
        chk("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, 32'h0);
        chk("stray_ack_valid", valid, 1'b0);
        man_ack = 1'b0; auto_mem = 1'b1;
        repeat (15) @(negedge clk);
        chk("seq_nreq", reqs.size() >= 3, 1'b1);
        chk("seq_nget", got.size() >= 3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", reqs[i], 32'(i * 4));
            chk("seq_pc", got[i][63:32], 32'(i * 4));
            chk("seq_instr", got[i][31:0], 32'(i * 4) ^ KEY);
        end
        chk("wrap_addr0", reqs2[0], 32'hFFFF_FFF8);
        chk("wrap_addr1", reqs2[1], 32'hFFFF_FFFC);
        chk("wrap_addr2", reqs2[2], 32'h0000_0000);
        chk("wrap_pc0", got2[0][63:32], 32'hFFFF_FFF8);
        chk("wrap_pc1", got2[1][63:32], 32'hFFFF_FFFC);
        chk("wrap_pc2", got2[2][63:32], 32'h0000_0000);

        // backpressure: queue fills to DEPTH and fetching stops
        id_ready = 1'b0;
        repeat (40) @(negedge clk);
        p0 = got.size();
        r0 = reqs.size();
        chk("fill_count", r0 - p0, 4);
        chk("fill_valid", valid, 1'b1);
        chk("fill_head", pc, 32'(p0 * 4));
        chk("fill_req_off", imem_req, 1'b0);
        repeat (3) @(negedge clk);
        chk("fill_req_still_off", imem_req, 1'b0);
        id_ready = 1'b1;
        repeat (30) @(negedge clk);
        chk("drain_resumed", reqs.size() > r0 + 2, 1'b1);
        chk("drain_npop", got.size() >= p0 + 6, 1'b1);
        for (int i = p0; i < p0 + 6; i++) begin
            chk("drain_pc", got[i][63:32], 32'(i * 4));
            chk("drain_instr", got[i][31:0], 32'(i * 4) ^ KEY);
        end

        // redirect while request for 0x8 is outstanding
        do_reset(1'b0);
        wait_req(32'h8, ok);
        chk("rd1_saw_req8", ok, 1'b1);
        chk("rd1_head_pc", pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        chk("rd1_flushed", valid, 1'b0);
        @(negedge clk);
        chk("rd1_gap", imem_req, 1'b0);
        id_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("rd1_next_addr", reqs[3], 32'h100);
        chk("rd1_first_pc", got[0][63:32], 32'h100);
        chk("rd1_first_instr", got[0][31:0], 32'h100 ^ KEY);

        // redirect coincident with the ack
        do_reset(1'b1);
        wait_req(32'h8, ok);
        chk("rd2_saw_req8", ok, 1'b1);
        auto_mem = 1'b0; man_ack = 1'b0;
        @(negedge clk);
        man_ack = 1'b1; man_rdata = 32'hBAD0_BAD0; redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        man_ack = 1'b0; redirect = 1'b0; auto_mem = 1'b1;
        chk("rd2_valid", valid, 1'b0);
        chk("rd2_req_gap", imem_req, 1'b0);
        @(negedge clk);
        chk("rd2_req", imem_req, 1'b1);
        chk("rd2_addr", imem_addr, 32'h200);
        repeat (12) @(negedge clk);
        chk("rd2_npop", got.size() >= 3, 1'b1);
        chk("rd2_pc1", got[1][63:32], 32'h4);
        chk("rd2_pc2", got[2][63:32], 32'h200);
        chk("rd2_instr2", got[2][31:0], 32'h200 ^ KEY);
        bad = 0;
        foreach (got[i]) if (got[i][31:0] == 32'hBAD0_BAD0) bad++;
        chk("rd2_no_dropped_data", bad, 0);

`ifdef IFETCH_PERF_EN
        begin
            int pops;
            do_reset(1'b0);
            chk("perf_rst_fetched", perf_fetched, 32'h0);
            chk("perf_rst_flushes", perf_flushes, 32'h0);
            repeat (20) @(negedge clk);
            pops = 0;
            for (int i = 0; i < 80 && pops < 5; i++) begin
                @(negedge clk);
                id_ready = valid;
                if (valid) pops++;
            end
            @(negedge clk);
            id_ready = 1'b0;
            chk("perf_pops_done", pops, 5);
            redirect = 1'b1; redirect_pc = 32'h300;
            @(negedge clk);
            redirect = 1'b0;
            repeat (2) @(negedge clk);
            redirect = 1'b1; redirect_pc = 32'h400;
            @(negedge clk);
            redirect = 1'b0;
            repeat (3) @(negedge clk);
            chk("perf_fetched", perf_fetched, 32'd5);
            chk("perf_flushes", perf_flushes, 32'd2);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            chk("perf_clr_fetched", perf_fetched, 32'h0);
            chk("perf_clr_flushes", perf_flushes, 32'h0);
            reset = 1'b0;
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4: fetch queue entries; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-006 SHALL have port imem_addr, output, 32 bits: fetch address, valid while imem_req=1.
REQ-007 SHALL have port imem_ack, input, 1 bit: memory response strobe.
REQ-008 SHALL have port imem_rdata, input, 32 bits: instruction word, valid when imem_ack=1.
REQ-009 SHALL have port redirect, input, 1 bit: flush and restart fetch, from branch/jump resolution.
REQ-010 SHALL have port redirect_pc, input, 32 bits: restart address, sampled when redirect=1.
REQ-011 SHALL have port id_ready, input, 1 bit: decode stage accepts the head entry this cycle.
REQ-012 SHALL have port valid, output, 1 bit: instr/pc hold a real instruction.
REQ-013 SHALL have port instr, output, 32 bits: instruction to decode.
REQ-014 SHALL have port pc, output, 32 bits: address of instr.

Function
REQ-015 SHALL hold fetch_pc; each accepted response SHALL push {fetch_pc, imem_rdata} into the queue and advance fetch_pc by 4, wrapping modulo 2^32.
REQ-016 SHALL allow at most one outstanding request; imem_req SHALL rise only when occupancy plus outstanding < DEPTH, so the queue never overflows.
REQ-017 SHALL hold imem_req=1 with imem_addr stable until the cycle imem_ack=1; imem_ack SHALL be ignored while no request is outstanding.
REQ-018 SHALL deassert imem_req in the cycle after the ack, reasserting no earlier than the following cycle (minimum 2-cycle request spacing).
REQ-019 SHALL drive valid=1 and head {pc, instr} whenever the queue is non-empty; when empty: valid=0, instr=NOP (32'h0000_0013), pc=0.
REQ-020 SHALL pop the head on valid && id_ready; push and pop in one cycle SHALL keep occupancy unchanged.
REQ-021 Redirect SHALL empty the queue next cycle and set fetch_pc=redirect_pc; an outstanding request SHALL still complete per REQ-017, but its response SHALL be discarded (drop flag).
REQ-022 Redirect coincident with imem_ack SHALL discard that response; coincident with a pop, the pop is void.
REQ-023 First request after redirect SHALL use redirect_pc, no earlier than the cycle after the discarded ack (or the cycle after redirect if nothing outstanding).
REQ-024 Redirect SHALL take priority over push, pop and pc increment.

Reset
REQ-025 While reset=1: queue empty, valid=0, instr=NOP, pc=0, imem_req=0, drop flag clear, fetch_pc=RESET_PC.
REQ-026 Reset mid-request SHALL abandon it; any ack in the first cycle after reset release SHALL be ignored.
REQ-027 First imem_req SHALL assert in the cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-028 With IFETCH_PERF_EN defined: outputs perf_fetched (32 bits, increments per pop) and perf_flushes (32 bits, increments per redirect cycle), both zeroed by reset and wrapping; undefined: ports and counters absent, behaviour otherwise identical.

Structure
REQ-029 Shared package SHALL hold the NOP constant, the fetch-entry struct {pc, instr} and instruction-width constants.
REQ-030 Queue SHALL be a sub-module fetch_fifo (push/pop/full/empty/flush, parameter DEPTH); ifetch owns pc, request and drop logic.

Verification
REQ-031 Reset release, 1-cycle-latency memory, id_ready=1 -> addresses 0x0,0x4,0x8 requested in order; valid with pc 0x0,0x4,0x8 and matching instr.
REQ-032 id_ready=0 held -> exactly DEPTH (4) entries fill, imem_req stays 0; id_ready=1 -> entries drain in order, fetching resumes.
REQ-033 Redirect to 0x100 while request for 0x8 outstanding -> 0x8 response dropped, valid=0 next cycle, next imem_addr=0x100.
REQ-034 Redirect to 0x200 coincident with imem_ack -> ack data never appears; next pc on output is 0x200.
REQ-035 RESET_PC=32'hFFFF_FFF8 -> fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 With IFETCH_PERF_EN: 5 pops and 2 redirects -> perf_fetched=5, perf_flushes=2; reset -> both 0.
